// File: rtl/rsa_modexp_core.sv
// Constant-time modular exponentiation, data_out = data_in^exp mod n.
// One bit-serial radix-2 Montgomery engine shared by every step of the ladder.
module rsa_modexp_core #(
  parameter int unsigned       n_bit  = 12,
  parameter logic [n_bit-1:0] n      = 12'd3551,
  parameter logic [n_bit-1:0] Rmodn  = 12'd545,
  parameter logic [n_bit-1:0] R2modn = 12'd2292
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [n_bit-1:0] exp,
  input  logic [n_bit-1:0] data_in,
  output logic [n_bit-1:0] data_out,
  output logic             done,
  output logic             busy
);

  localparam int W  = n_bit + 2;
  localparam int CW = $clog2(n_bit + 1);
  localparam int IW = $clog2(n_bit);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_TOMONT,
    S_SQR,
    S_MUL,
    S_FROM,
    S_DONE
  } state_t;

  state_t st, nxt;

  logic [n_bit-1:0] base_r;
  logic [n_bit-1:0] ex_r;
  logic [n_bit-1:0] acc;
  logic [n_bit-1:0] xm;
  logic [IW-1:0]    idx;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     a_r;

  logic [n_bit-1:0] op_a;
  logic [n_bit-1:0] op_b;
  logic             a_bit;
  logic [W-1:0]     sum1;
  logic [W-1:0]     sum2;
  logic [W-1:0]     a_next;
  logic [n_bit-1:0] res;
  logic             mp_last;

  assign mp_last = (cnt == CW'(n_bit));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= S_IDLE;
    else        st <= nxt;
  end

  always_comb begin
    nxt = st;
    unique case (st)
      S_IDLE:   if (start) nxt = S_LOAD;
      S_LOAD:   nxt = S_TOMONT;
      S_TOMONT: if (mp_last) nxt = S_SQR;
      S_SQR:    if (mp_last) nxt = S_MUL;
      S_MUL: begin
        if (mp_last)
          nxt = (idx == '0) ? S_FROM : S_SQR;
      end
      S_FROM:   if (mp_last) nxt = S_DONE;
      S_DONE:   if (!start) nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  // Operand select for the shared Montgomery engine
  always_comb begin
    op_a = '0;
    op_b = '0;
    unique case (st)
      S_TOMONT: begin
        op_a = base_r;
        op_b = R2modn;
      end
      S_SQR: begin
        op_a = acc;
        op_b = acc;
      end
      S_MUL: begin
        op_a = acc;
        op_b = xm;
      end
      S_FROM: begin
        op_a = acc;
        op_b = n_bit'(1);
      end
      default: ;
    endcase
  end

  // A stays below 2n, so A + b + n fits in n_bit+2 bits
  always_comb begin
    a_bit  = |(op_a & (n_bit'(1) << cnt));
    sum1   = a_r + (a_bit ? {2'b00, op_b} : '0);
    sum2   = sum1[0] ? sum1 + W'(n) : sum1;
    a_next = sum2 >> 1;
    res    = n_bit'((a_r >= W'(n)) ? a_r - W'(n) : a_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_r   <= '0;
      ex_r     <= '0;
      acc      <= '0;
      xm       <= '0;
      idx      <= '0;
      cnt      <= '0;
      a_r      <= '0;
      data_out <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (st)
        S_IDLE: begin
          if (start) begin
            base_r <= data_in;
            ex_r   <= exp;
            busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          acc <= Rmodn;
          idx <= IW'(n_bit - 1);
          cnt <= '0;
          a_r <= '0;
        end
        S_TOMONT, S_SQR, S_MUL, S_FROM: begin
          if (!mp_last) begin
            cnt <= cnt + 1'b1;
            a_r <= a_next;
          end else begin
            cnt <= '0;
            a_r <= '0;
            unique case (st)
              S_TOMONT: xm <= res;
              S_SQR:    acc <= res;
              S_MUL: begin
                if (ex_r[idx]) acc <= res;
                if (idx != '0) idx <= idx - 1'b1;
              end
              default: begin
                data_out <= res;
                done     <= 1'b1;
                busy     <= 1'b0;
              end
            endcase
          end
        end
        S_DONE: if (!start) done <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Scoreboard bench for rsa_modexp_core: result value and 339-cycle latency.
// Expected values come from constants or an integer square-and-multiply model.
module tb_rsa_modexp_core;

  localparam int LAT = 339;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] exp_i = '0;
  logic [11:0] data_in = '0;
  logic [11:0] data_out;
  logic        done;
  logic        busy;

  rsa_modexp_core dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .exp      (exp_i),
    .data_in  (data_in),
    .data_out (data_out),
    .done     (done),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [11:0] val;
    int          acc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [11:0] pmod(input int unsigned b,
                                       input int unsigned e);
    longint unsigned r = 1;
    longint unsigned x = b % 3551;
    int unsigned     k = e;
    while (k != 0) begin
      if (k[0]) r = (r * x) % 3551;
      x = (x * x) % 3551;
      k = k >> 1;
    end
    return 12'(r);
  endfunction

  // Monitor: every rising done pops one expectation
  logic pd = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (done && busy) begin
      errors++;
      $display("FAIL done_busy_overlap: done=%0b busy=%0b at cycle %0d",
               done, busy, cyc);
    end
    if (done && !pd) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: data_out=%0d at cycle %0d",
                 data_out, cyc);
      end else begin
        e = sb.pop_front();
        checks += 2;
        if (data_out !== e.val) begin
          errors++;
          $display("FAIL %s result: got %0d expected %0d",
                   e.name, data_out, e.val);
        end
        if (cyc - e.acc != LAT) begin
          errors++;
          $display("FAIL %s latency: got %0d expected %0d",
                   e.name, cyc - e.acc, LAT);
        end
      end
    end
    pd = done;
  end

  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (done) break;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: done=%0b expected 1", nm, done);
    end
  endtask

  task automatic op(input logic [11:0] b, input logic [11:0] e,
                    input logic [11:0] val, input string nm,
                    input bit pulse, input bit toggle);
    exp_t it;
    @(negedge clk);
    data_in = b;
    exp_i   = e;
    start   = 1'b1;
    @(posedge clk);
    #1;
    it.val  = val;
    it.acc  = cyc;
    it.name = nm;
    sb.push_back(it);
    if (pulse) begin
      @(negedge clk);
      start = 1'b0;
    end
    if (toggle) begin
      repeat (40) @(negedge clk);
      data_in = 12'($urandom);
      exp_i   = 12'($urandom);
      repeat (100) @(negedge clk);
      data_in = ~b;
      exp_i   = ~e;
    end
    wait_done(nm);
    if (pulse) begin
      @(negedge clk);
      chk({nm, "_done_one_cycle"}, int'(done), 0);
    end else begin
      repeat (20) @(negedge clk);
      chk({nm, "_hold_done"}, int'({done, busy}), 2);
      start = 1'b0;
      @(negedge clk);
      chk({nm, "_drop_done"}, int'(done), 0);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] c, rb, re;
    logic [11:0] lb[4];
    lb[0] = 12'd2;
    lb[1] = 12'd100;
    lb[2] = 12'd1234;
    lb[3] = 12'd3000;

    repeat (3) @(negedge clk);
    chk("reset_done", int'(done), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_data", int'(data_out), 0);
    rst_n = 1'b1;

    op(12'd2, 12'd5, 12'd32, "pow_2_5", 0, 0);
    op(12'd32, 12'd1373, 12'd2, "dec_32", 0, 0);
    foreach (lb[i]) begin
      c = pmod(lb[i], 5);
      op(lb[i], 12'd5, c, "enc", 0, 0);
      op(c, 12'd1373, lb[i], "loopback", 0, 0);
    end

    op(12'd1234, 12'd0, 12'd1, "exp0", 0, 0);
    op(12'd0, 12'd0, 12'd1, "zero_pow_zero", 0, 0);
    op(12'd3551, 12'd5, 12'd0, "base_eq_n", 0, 0);
    op(12'd3550, 12'd5, 12'd3550, "base_n_minus1", 0, 0);
    op(12'd4095, 12'd1, 12'd544, "base_max", 0, 0);

    op(12'd2, 12'd5, 12'd32, "pulse", 1, 0);
    op(12'd100, 12'd1373, pmod(100, 1373), "toggle", 1, 1);

    // Abort an operation with reset at cycle 150
    @(negedge clk);
    data_in = 12'd2;
    exp_i   = 12'd5;
    start   = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    start = 1'b0;
    repeat (149) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_done", int'(done), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_data", int'(data_out), 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(12'd2, 12'd5, 12'd32, "after_abort", 0, 0);

    for (int k = 0; k < 8; k++) begin
      rb = 12'($urandom);
      re = 12'($urandom);
      op(rb, re, pmod(rb, re), "random", 0, 0);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rsa_modexp_core.md
Name: rsa_modexp_core

Overview:
Shared Montgomery modular-exponentiation responder for the level-start/done handshake used by the RSA encoder/decoder benches. It computes data_out = data_in^exp mod n, taking the exponent as a run-time port so one core can serve the public-key and private-key paths. It uses bit-serial radix-2 Montgomery products and a constant-time left-to-right square-and-always-multiply schedule.

Parameters:
n, 12'd3551, odd modulus, n < 2^n_bit
n_bit, 12, operand/modulus width; Montgomery R = 2^n_bit
Rmodn, 12'd545, R mod n (Montgomery form of 1)
R2modn, 12'd2292, R^2 mod n (to-Montgomery conversion constant)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous reset, active low
start  in  1  level request; sampled high in IDLE begins an operation; held high by the initiator until done seen
exp  in  n_bit  exponent, sampled with start
data_in  in  n_bit  base, sampled with start; any value 0..2^n_bit-1 is legal
data_out  out  n_bit  result, registered, valid while done=1, held until next accept
done  out  1  completion flag, registered
busy  out  1  high while computing

Behaviour:
- Reset (async, rst_n=0): state=IDLE; data_out=0, done=0, busy=0; all datapath registers 0. Reset mid-operation aborts; there is no output glitch after release.
- States: IDLE -> LOAD -> TOMONT -> SQR -> MUL -> (SQR or FROMMONT) -> DONE -> IDLE.
- IDLE: when start=1 on an edge, latch data_in/exp, set busy=1, go to LOAD.
- LOAD (1 cycle): acc=Rmodn, bit index i=n_bit-1.
- MonPro(a,b): A=0; for k=0..n_bit-1: A=A+a[k]*b; if A odd then A=A+n; A=A>>1. Then one cycle for the final step: if A>=n then A=A-n.
  - Cost is exactly n_bit+1 cycles.
  - Internal width is n_bit+2 bits; there is no overflow since A<2n.
- TOMONT: xm=MonPro(data_in_latched, R2modn). This is correct for base >= n because base<R and R2modn<n.
- SQR: acc=MonPro(acc,acc).
- MUL: t=MonPro(acc,xm) is always computed. acc=t if exp[i]=1, else acc is unchanged.
  - If i>0: decrement i and go to SQR.
  - If i=0: go to FROMMONT.
- FROMMONT: result=MonPro(acc,1). Load data_out, set done=1, clear busy, go to DONE.
- Total MonPro count is 2*n_bit+2.
- Latency: done rises exactly 1+(2*n_bit+2)*(n_bit+1) edges after the accepting edge. This is 339 cycles for n_bit=12 and is independent of the data (constant time).
- DONE: done and data_out hold while start=1. On the first edge with start=0, go to IDLE and clear done. If start was already low on entry, done is high for exactly one cycle.
- start falling mid-computation is ignored; the operation completes normally.
- start high in DONE never re-triggers. A new operation requires start low (IDLE), then high again.
- exp/data_in changes after the accept edge have no effect.
- Boundaries:
  - exp=0 gives 1, including data_in=0.
  - data_in ≡ 0 mod n with exp>0 gives 0.
  - Result is always < n.
- busy=1 from the accept edge+1 until the edge done rises. done and busy are never both 1.

Test Plan:
- Reset, then data_in=2, exp=5, start held -> done after 339 cycles, data_out=32. Drop start -> done=0 next edge, state IDLE.
- data_in=32, exp=1373 -> data_out=2. Encoder-to-decoder loopback of 2, 100, 1234, 3000 with e=5 then d=1373 returns each input exactly.
- Boundaries:
  - exp=0, data_in=1234 -> 1.
  - data_in=3551, exp=5 -> 0.
  - data_in=3550, exp=5 -> 3550.
  - data_in=4095, exp=1 -> 544.
- Handshake: start pulsed one cycle only -> completes, done high exactly one cycle. Toggling exp/data_in mid-operation does not change the result. start held high after done -> no second operation starts.
- Reset asserted at cycle 150 of an operation -> done/busy/data_out=0 immediately. Next operation (2,5) -> 32 with full 339-cycle latency.
- Latency check: for 8 random (data_in, exp) pairs, done edge is exactly 339 cycles after accept, and results match a reference pow-mod.
